// File: rtl/hsv_pkg.sv
// hsv_pkg: limits and types shared by the HSV control block and hsv_to_rgb.
package hsv_pkg;
    localparam logic [8:0] HUE_MAX    = 9'd360;
    localparam logic [8:0] SV_MAX     = 9'd100;
    localparam logic [8:0] SECTOR_DEG = 9'd60;
    localparam logic [7:0] RGB_MAX    = 8'd255;
    typedef logic [2:0] sector_t;
    typedef logic [7:0] rgb8_t;
endpackage

// File: rtl/rgb_pwm.sv
// rgb_pwm: 8-bit PWM for the RGB LED; duties latch only at period start.
module rgb_pwm
    import hsv_pkg::*;
#(
    parameter int PWM_DIV = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  rgb8_t red,
    input  rgb8_t green,
    input  rgb8_t blue,
    output logic  pwm_r,
    output logic  pwm_g,
    output logic  pwm_b
);
    localparam int PW = PWM_DIV > 1 ? $clog2(PWM_DIV) : 1;
    logic [PW-1:0] pre;
    rgb8_t pwm_cnt, duty_r, duty_g, duty_b;
    logic tc;
    assign tc = pre == PW'(PWM_DIV - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre     <= '0;
            pwm_cnt <= '0;
            duty_r  <= '0;
            duty_g  <= '0;
            duty_b  <= '0;
            pwm_r   <= 1'b0;
            pwm_g   <= 1'b0;
            pwm_b   <= 1'b0;
        end else begin
            pre <= tc ? '0 : pre + 1'b1;
            if (tc) pwm_cnt <= pwm_cnt + 1'b1;
            // loading only on the wrap keeps every period at one duty
            if (tc && pwm_cnt == RGB_MAX) begin
                duty_r <= red;
                duty_g <= green;
                duty_b <= blue;
            end
            pwm_r <= pwm_cnt < duty_r;
            pwm_g <= pwm_cnt < duty_g;
            pwm_b <= pwm_cnt < duty_b;
        end
    end
endmodule

// File: rtl/hsv_to_rgb.sv
// hsv_to_rgb: 4-stage HSV to 8-bit RGB pipeline, one sample per cycle.
// Define HSV_PWM_EN to add the rgb_pwm LED drive and its pwm_r/g/b ports.
module hsv_to_rgb
    import hsv_pkg::*;
`ifdef HSV_PWM_EN
#(
    parameter int PWM_DIV = 4
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [8:0] Hue,
    input  logic [8:0] Saturation,
    input  logic [8:0] Value,
    output logic       out_valid,
    output rgb8_t      Red,
    output rgb8_t      Green,
    output rgb8_t      Blue
`ifdef HSV_PWM_EN
    ,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b
`endif
);
    logic v1, v2, v3;
    sector_t sec1, sec2, sec3;
    logic [5:0] f1, f2;
    logic [6:0] s1;
    rgb8_t vmax1, vmax2, vmax3, vmin2, vmin3, vinc3, vdec3;
    logic [8:0] h, s, v;
    logic [14:0] vm, cp;
    logic [13:0] ap;
    rgb8_t c, a;
    logic [23:0] sel;
    always_comb begin
        h  = Hue >= HUE_MAX ? 9'd0 : Hue;
        s  = Saturation > SV_MAX ? SV_MAX : Saturation;
        v  = Value > SV_MAX ? SV_MAX : Value;
        vm = 15'(v) * 15'(RGB_MAX) + 15'd50;
        cp = 15'(vmax1) * 15'(s1);
        c  = rgb8_t'(cp / 15'(SV_MAX));
        ap = 14'(c2_unused_guard(f2)) * 14'(vmax2 - vmin2);
        a  = rgb8_t'(ap / 14'(SECTOR_DEG));
    end
    // C is carried as vmax-vmin so stage 2 only stores vmin
    function automatic logic [5:0] c2_unused_guard(input logic [5:0] x);
        return x;
    endfunction
    always_comb begin
        case (sec3)
            3'd0:    sel = {vmax3, vinc3, vmin3};
            3'd1:    sel = {vdec3, vmax3, vmin3};
            3'd2:    sel = {vmin3, vmax3, vinc3};
            3'd3:    sel = {vmin3, vdec3, vmax3};
            3'd4:    sel = {vinc3, vmin3, vmax3};
            default: sel = {vmax3, vmin3, vdec3};
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {v1, v2, v3, out_valid} <= '0;
            {sec1, sec2, sec3}      <= '0;
            {f1, f2, s1}            <= '0;
            {vmax1, vmax2, vmax3}   <= '0;
            {vmin2, vmin3}          <= '0;
            {vinc3, vdec3}          <= '0;
            {Red, Green, Blue}      <= '0;
        end else begin
            v1    <= in_valid;
            sec1  <= sector_t'(h / SECTOR_DEG);
            f1    <= 6'(h % SECTOR_DEG);
            vmax1 <= rgb8_t'(vm / 15'(SV_MAX));
            s1    <= 7'(s);
            v2    <= v1;
            sec2  <= sec1;
            f2    <= f1;
            vmax2 <= vmax1;
            vmin2 <= vmax1 - c;
            v3    <= v2;
            sec3  <= sec2;
            vmax3 <= vmax2;
            vmin3 <= vmin2;
            vinc3 <= vmin2 + a;
            vdec3 <= vmax2 - a;
            out_valid <= v3;
            if (v3) {Red, Green, Blue} <= sel;
        end
    end
`ifdef HSV_PWM_EN
    rgb_pwm #(.PWM_DIV(PWM_DIV)) u_pwm (
        .clk   (clk),
        .reset (reset),
        .red   (Red),
        .green (Green),
        .blue  (Blue),
        .pwm_r (pwm_r),
        .pwm_g (pwm_g),
        .pwm_b (pwm_b)
    );
`endif
endmodule

// File: tb/tb_hsv_to_rgb.sv
// tb_hsv_to_rgb: directed vectors, streaming, async reset and (with HSV_PWM_EN) PWM checks.
module tb_hsv_to_rgb;
    import hsv_pkg::*;
    logic clk = 1'b0;
    logic reset, in_valid;
    logic [8:0] Hue, Saturation, Value;
    logic out_valid;
    rgb8_t Red, Green, Blue;
`ifdef HSV_PWM_EN
    logic pwm_r, pwm_g, pwm_b;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

`ifdef HSV_PWM_EN
    hsv_to_rgb #(.PWM_DIV(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .Hue        (Hue),
        .Saturation (Saturation),
        .Value      (Value),
        .out_valid  (out_valid),
        .Red        (Red),
        .Green      (Green),
        .Blue       (Blue),
        .pwm_r      (pwm_r),
        .pwm_g      (pwm_g),
        .pwm_b      (pwm_b)
    );
`else
    hsv_to_rgb dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .Hue        (Hue),
        .Saturation (Saturation),
        .Value      (Value),
        .out_valid  (out_valid),
        .Red        (Red),
        .Green      (Green),
        .Blue       (Blue)
    );
`endif

    typedef struct {
        logic [8:0]  h, s, v;
        logic [23:0] rgb;
    } vec_t;
    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // single in_valid pulse; lat is the edge index (0 = accepting edge) where out_valid first rises
    task automatic convert(input logic [8:0] h, s, v, output int lat, output logic [23:0] rgb);
        @(negedge clk);
        Hue = h;
        Saturation = s;
        Value = v;
        in_valid = 1'b1;
        lat = -1;
        rgb = '0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) in_valid = 1'b0;
            if (out_valid && lat < 0) begin
                lat = k;
                rgb = {Red, Green, Blue};
            end
        end
    endtask

    function automatic logic [23:0] prim(input logic [8:0] h);
        case (h)
            9'd0:    return 24'hFF0000;
            9'd60:   return 24'hFFFF00;
            9'd120:  return 24'h00FF00;
            9'd180:  return 24'h00FFFF;
            9'd240:  return 24'h0000FF;
            9'd300:  return 24'hFF00FF;
            default: return 24'hFF7F00;
        endcase
    endfunction

    initial begin
        int lat, hi, ov_seen;
        logic [23:0] rgb;
        bit sv[12] = '{1, 1, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0};
        logic [8:0] sh[12] = '{0, 60, 120, 180, 240, 300, 0, 30, 0, 0, 0, 0};
        vecs[0]  = '{9'd0,   9'd100, 9'd100, 24'hFF0000};
        vecs[1]  = '{9'd120, 9'd100, 9'd100, 24'h00FF00};
        vecs[2]  = '{9'd240, 9'd100, 9'd100, 24'h0000FF};
        vecs[3]  = '{9'd30,  9'd100, 9'd100, 24'hFF7F00};
        vecs[4]  = '{9'd240, 9'd50,  9'd50,  24'h404080};
        vecs[5]  = '{9'd200, 9'd70,  9'd0,   24'h000000};
        vecs[6]  = '{9'd360, 9'd100, 9'd100, 24'hFF0000};
        vecs[7]  = '{9'd500, 9'd100, 9'd100, 24'hFF0000};
        vecs[8]  = '{9'd60,  9'd300, 9'd200, 24'hFFFF00};
        vecs[9]  = '{9'd180, 9'd100, 9'd100, 24'h00FFFF};
        vecs[10] = '{9'd300, 9'd100, 9'd100, 24'hFF00FF};
        vecs[11] = '{9'd359, 9'd100, 9'd100, 24'hFF0005};
        vecs[12] = '{9'd90,  9'd40,  9'd80,  24'hA4CC7B};
        vecs[13] = '{9'd200, 9'd100, 9'd1,   24'h000203};
        vecs[14] = '{9'd100, 9'd0,   9'd100, 24'hFFFFFF};

        reset = 1'b1;
        in_valid = 1'b0;
        Hue = '0;
        Saturation = '0;
        Value = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_rgb", 32'({Red, Green, Blue}), 0);
`ifdef HSV_PWM_EN
        chk("reset_pwm", 32'({pwm_r, pwm_g, pwm_b}), 0);
`endif
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            convert(vecs[i].h, vecs[i].s, vecs[i].v, lat, rgb);
            chk($sformatf("latency[%0d]", i), lat, 3);
            chk($sformatf("rgb[%0d]", i), 32'(rgb), 32'(vecs[i].rgb));
            chk($sformatf("hold[%0d]", i), 32'({out_valid, Red, Green, Blue}), 32'(vecs[i].rgb));
        end

        // back-to-back samples with a one-cycle bubble
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            in_valid = sv[k];
            Hue = sh[k];
            Saturation = 9'd100;
            Value = 9'd100;
            @(posedge clk);
            #1;
            chk($sformatf("stream_valid[%0d]", k), 32'(out_valid), k >= 3 ? 32'(sv[k-3]) : 0);
            if (k >= 3 && sv[k-3])
                chk($sformatf("stream_rgb[%0d]", k), 32'({Red, Green, Blue}), 32'(prim(sh[k-3])));
        end
        in_valid = 1'b0;

        // async reset with three samples in flight
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            Hue = 9'(k * 120);
            @(posedge clk);
        end
        #2 reset = 1'b1;
        #1;
        in_valid = 1'b0;
        chk("async_reset_valid", 32'(out_valid), 0);
        chk("async_reset_rgb", 32'({Red, Green, Blue}), 0);
        @(negedge clk);
        reset = 1'b0;
        ov_seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            ov_seen += int'(out_valid);
        end
        chk("flushed_valid", ov_seen, 0);
        convert(9'd120, 9'd100, 9'd100, lat, rgb);
        chk("post_reset_latency", lat, 3);
        chk("post_reset_rgb", 32'(rgb), 32'h00FF00);

`ifdef HSV_PWM_EN
        convert(9'd0, 9'd100, 9'd25, lat, rgb);
        chk("pwm_red64", 32'(rgb), 32'h400000);
        lat = 0;
        for (int k = 0; k < 1200 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (pwm_r) lat = 1;
        end
        chk("pwm_sync", lat, 1);
        // duty change mid-period must wait for the next period
        hi = 1;
        for (int k = 1; k < 256; k++) begin
            @(posedge clk);
            #1;
            if (k == 10) begin
                Hue = 9'd0;
                Saturation = 9'd100;
                Value = 9'd50;
                in_valid = 1'b1;
            end
            if (k == 11) in_valid = 1'b0;
            hi += int'(pwm_r);
        end
        chk("pwm_period64", hi, 64);
        chk("pwm_red128", 32'(Red), 32'd128);
        hi = 0;
        repeat (256) begin
            @(posedge clk);
            #1;
            hi += int'(pwm_r);
        end
        chk("pwm_period128", hi, 128);
        convert(9'd0, 9'd100, 9'd0, lat, rgb);
        repeat (600) @(posedge clk);
        hi = 0;
        repeat (512) begin
            @(posedge clk);
            #1;
            hi += int'(pwm_r);
        end
        chk("pwm_duty0", hi, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hsv_to_rgb.md
Name: hsv_to_rgb

Overview:
- Downstream stage of the HSV control block: consumes Hue (0..360), Saturation (0..100) and Value (0..100) and produces 8-bit R/G/B for the board RGB LED.
- Fixed 4-stage pipeline with valid tagging; accepts a new sample every cycle.
- Optional PWM back end drives the LED pins directly.

Parameters:
- PWM_DIV, 4, clock cycles per PWM counter step; integer ≥1; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  Hue/Saturation/Value sample valid this cycle (top may tie to 1)
- Hue  in  9  hue in degrees, nominal 0..360
- Saturation  in  9  saturation percent, nominal 0..100
- Value  in  9  value percent, nominal 0..100
- out_valid  out  1  Red/Green/Blue hold a converted sample
- Red  out  8  red intensity 0..255
- Green  out  8  green intensity 0..255
- Blue  out  8  blue intensity 0..255
- pwm_r, pwm_g, pwm_b  out  1 each  PWM LED drive; present only with HSV_PWM_EN

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: all pipeline registers 0; out_valid=0; Red=Green=Blue=0.
- Reset mid-operation: any sample in flight is discarded, with no out_valid pulse.
- Latency: a sample accepted at edge N (in_valid=1) appears with out_valid=1 after edge N+3, i.e. 4 registered stages. Throughput is 1 per cycle.
- When in_valid=0 a bubble propagates. Red/Green/Blue hold their last value while out_valid=0.
- Input clamping (stage 1):
  - H = 0 if Hue≥360, else Hue.
  - S = min(Saturation,100).
  - V = min(Value,100).
- Arithmetic (all results floor, exact integer):
  - Stage 1: sector = H/60 (0..5); f = H%60; vmax = (V*255+50)/100, range 0..255.
  - Stage 2: C = vmax*S/100; vmin = vmax−C.
  - Stage 3: a = C*f/60; vinc = vmin+a; vdec = vmax−a. All stay within 0..255, so no overflow handling is needed.
  - Stage 4, channel select (R,G,B):
    - sector 0: vmax, vinc, vmin
    - sector 1: vdec, vmax, vmin
    - sector 2: vmin, vmax, vinc
    - sector 3: vmin, vdec, vmax
    - sector 4: vinc, vmin, vmax
    - sector 5: vmax, vmin, vdec
- Constant divisions (/60, /100) are combinational inside their stage. Any implementation must be bit-exact with floor division over the full clamped input range.
- Intermediate widths: vmax*S ≤ 25500 (15 bits); C*f ≤ 15045 (14 bits); V*255+50 ≤ 25550 (15 bits).

Optional Feature:
- Macro: HSV_PWM_EN.
- Defined:
  - Prescaler counts 0..PWM_DIV−1. On its terminal count, an 8-bit counter pwm_cnt increments and wraps 255→0.
  - Duty registers duty_r/g/b load from Red/Green/Blue only when pwm_cnt wraps to 0 together with a prescaler terminal count. This gives glitch-free period updates.
  - pwm_x = (pwm_cnt < duty_x), registered. Duty 0 gives constant low; duty 255 gives high 255 of every 256 steps.
  - Reset: prescaler, pwm_cnt and duties all 0; pwm outputs 0.
- Undefined: no PWM logic and no pwm_* ports. Red/Green/Blue behaviour is unchanged.

Decomposition:
- Shared package hsv_pkg:
  - constants HUE_MAX=360, SV_MAX=100, SECTOR_DEG=60, RGB_MAX=255
  - typedef sector_t (3 bits)
  - typedef rgb8_t (8 bits)
  - The HSV control block reuses these limits.
- One natural sub-module: rgb_pwm (prescaler, counter, duty latch, comparators), instantiated only under HSV_PWM_EN.
- The conversion pipeline stays in hsv_to_rgb.

Test Plan:
- H=0,S=100,V=100, single in_valid pulse → out_valid exactly 4 edges later; R=255,G=0,B=0. H=120 → 0,255,0. H=240 → 0,0,255.
- H=30,S=100,V=100 → 255,127,0. H=240,S=50,V=50 → 64,64,128. V=0 with any H/S → 0,0,0.
- Clamping: Hue=360 and Hue=500 → same as H=0. Saturation=300,Value=200 → same as S=100,V=100.
- Back-to-back: in_valid=1 for 6 cycles with H=0,60,120,180,240,300 (S=V=100) → out_valid high for 6 consecutive cycles with matching primaries/secondaries in order. A 1-cycle in_valid gap → 1-cycle out_valid gap.
- Reset asserted asynchronously while 3 samples are in flight → outputs 0 immediately and no out_valid after release. The next sample converts correctly.
- HSV_PWM_EN, PWM_DIV=1, Red=64: pwm_r high for exactly 64 of 256 cycles per period. A Red change mid-period takes effect only at the next period start. Duty 0 → pwm_r never high.
